// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save accumulator sequencer.
// Holds the state encoding, default widths and the chunk-index width.
package csa_pkg;

   localparam int unsigned W_DEF     = 186;
   localparam int unsigned CHUNK_DEF = 62;
   localparam int unsigned NCHUNK    = W_DEF / CHUNK_DEF;
   localparam int unsigned KW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t ACC  = 2'd1;
   localparam state_t RES  = 2'd2;
   localparam state_t OUT  = 2'd3;

endpackage

// File: rtl/csa_acc_sched_if.sv
// Addend input and result output handshake bundle for csa_acc_sched.
// in_neg exists only when CSA_ACC_SUB_EN is defined.
interface csa_acc_sched_if
   import csa_pkg::*;
#(
   parameter int unsigned W = W_DEF
) ();

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
`ifdef CSA_ACC_SUB_EN
   logic         in_neg;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

`ifdef CSA_ACC_SUB_EN
   modport master (output in_valid, in_data, in_last, in_neg, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, in_last, in_neg, out_ready,
                   output in_ready, out_valid, out_data);
`else
   modport master (output in_valid, in_data, in_last, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/csa_186.sv
// 186-bit 3:2 carry-save stage; carry output pre-shifted, top carry dropped.
module csa_186 (
   input  logic [185:0] x,
   input  logic [185:0] y,
   input  logic [185:0] z,
   output logic [185:0] s,
   output logic [185:0] c
);

   logic [185:0] maj;

   assign maj = (x & y) | (x & z) | (y & z);
   assign s   = x ^ y ^ z;
   assign c   = {maj[184:0], 1'b0};

endmodule

// File: rtl/csa_acc_sched.sv
// Folds a stream of addends into a redundant carry/sum pair, then resolves it
// with a chunked CPA. Optional subtraction enabled by macro CSA_ACC_SUB_EN.
module csa_acc_sched
   import csa_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CHUNK = CHUNK_DEF,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   csa_acc_sched_if.slave   bus,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             busy
);

   localparam int unsigned NCH = W / CHUNK;
   localparam int unsigned KLW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t           state, state_nx;
   logic [KLW-1:0]   k, k_nx;
   logic             in_ready_q, in_ready_nx;
   logic             out_valid_q, out_valid_nx;
   logic             busy_q, busy_nx;

   logic [W-1:0]     c_reg, s_reg, out_data_q;
   logic [W-1:0]     csa_x_c, csa_s_c, csa_c_c;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [1:0]       cy, cy_in_c;
   logic [31:0]      base_c;
   logic [CHUNK+1:0] neg_ext_c, slice_sum_c;
   logic             accept_c, clear_c;

   assign accept_c = bus.in_valid & in_ready_q;
   assign clear_c  = (state == OUT) & bus.out_ready;

`ifdef CSA_ACC_SUB_EN
   logic [CNT_W-1:0] neg_cnt;
   assign csa_x_c   = bus.in_neg ? ~bus.in_data : bus.in_data;
   assign neg_ext_c = (k == '0) ? (CHUNK+2)'(neg_cnt) : '0;
`else
   assign csa_x_c   = bus.in_data;
   assign neg_ext_c = '0;
`endif

   csa_186 u_csa (
      .x (csa_x_c),
      .y (s_reg),
      .z (c_reg),
      .s (csa_s_c),
      .c (csa_c_c)
   );

   // One CPA slice per RES cycle; cy is forced to zero on the low slice.
   assign base_c      = 32'(k) * CHUNK;
   assign cy_in_c     = (k == '0) ? 2'd0 : cy;
   assign slice_sum_c = {2'b00, s_reg[base_c +: CHUNK]}
                      + {2'b00, c_reg[base_c +: CHUNK]}
                      + (CHUNK+2)'(cy_in_c)
                      + neg_ext_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         k           <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         k           <= k_nx;
         in_ready_q  <= in_ready_nx;
         out_valid_q <= out_valid_nx;
         busy_q      <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      k_nx     = k;
      case (state)
         IDLE, ACC: begin
            if (accept_c) begin
               state_nx = bus.in_last ? RES : ACC;
               k_nx     = '0;
            end
         end
         RES: begin
            if (k == KLW'(NCH - 1)) begin
               state_nx = OUT;
               k_nx     = '0;
            end else begin
               k_nx = k + KLW'(1);
            end
         end
         OUT: begin
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      in_ready_nx  = (state_nx == IDLE) || (state_nx == ACC);
      out_valid_nx = (state_nx == OUT);
      busy_nx      = (state_nx != IDLE);
   end

   // Redundant accumulator, counters and resolved result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_reg      <= '0;
         s_reg      <= '0;
         out_data_q <= '0;
         beat_cnt_q <= '0;
         cy         <= 2'd0;
`ifdef CSA_ACC_SUB_EN
         neg_cnt    <= '0;
`endif
      end else begin
         if (accept_c) begin
            c_reg <= csa_c_c;
            s_reg <= csa_s_c;
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
`ifdef CSA_ACC_SUB_EN
            if (bus.in_neg) neg_cnt <= neg_cnt + CNT_W'(1);
`endif
         end
         if (state == RES) begin
            out_data_q[base_c +: CHUNK] <= slice_sum_c[CHUNK-1:0];
            cy                          <= slice_sum_c[CHUNK +: 2];
         end
         if (clear_c) begin
            c_reg      <= '0;
            s_reg      <= '0;
            beat_cnt_q <= '0;
`ifdef CSA_ACC_SUB_EN
            neg_cnt    <= '0;
`endif
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign beat_cnt      = beat_cnt_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_csa_acc_sched.sv
// Self-checking bench for csa_acc_sched: directed and random sums against a
// plain-arithmetic reference (sum of signed addends mod 2^W).
module tb_csa_acc_sched;
   import csa_pkg::*;

   localparam int unsigned W     = 186;
   localparam int unsigned CHUNK = 62;
   localparam int unsigned CNT_W = 8;
   localparam int          LAT   = 3;   // edges from last accept to out_valid seen

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] beat_cnt;
   logic             busy;

   csa_acc_sched_if #(.W(W)) bus ();

   csa_acc_sched #(.W(W), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .beat_cnt (beat_cnt),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           total;
   int           bad;
   logic [W-1:0] bd [512];
   bit           bn [512];
   bit           tmo;

   function automatic logic [W-1:0] rand_w();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(3, 0))
         0:       return '1;
         1:       return W'($urandom_range(15, 0));
         default: return t[W-1:0];
      endcase
   endfunction

   function automatic logic [W-1:0] model(input int n);
      logic [W-1:0] acc;
      acc = '0;
      for (int i = 0; i < n; i++) acc = bn[i] ? acc - bd[i] : acc + bd[i];
      return acc;
   endfunction

   task automatic clear_beats();
      for (int i = 0; i < 512; i++) begin
         bd[i] = '0;
         bn[i] = 1'b0;
      end
   endtask

   // Presents n beats, optional random idle gaps; returns #1 after last accept.
   task automatic drive_sum(input int n, input int gap_max);
      int w;
      tmo = 1'b0;
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         @(negedge clk);
         if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = bd[i];
         bus.in_last  = (i == n - 1);
`ifdef CSA_ACC_SUB_EN
         bus.in_neg   = bn[i];
`endif
         w = 0;
         while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (!bus.in_ready) begin
            tmo = 1'b1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            return;
         end
      end
   endtask

   task automatic consume(input int hold);
      repeat (hold) @(negedge clk);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (beat_cnt !== '0) begin bad++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
      total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      int lat;
      clear_beats();
      bd[0] = W'(32'h1234);
      drive_sum(1, 0);
      total++; if (tmo) begin bad++; $display("FAIL single_accept got=timeout want=accepted"); end
      wait_out(lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, LAT); end
      total++; if (bus.out_data !== W'(32'h1234)) begin bad++; $display("FAIL single_data got=%h want=1234", bus.out_data); end
      total++; if (beat_cnt !== CNT_W'(1)) begin bad++; $display("FAIL single_beat_cnt got=%0d want=1", beat_cnt); end
      total++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_out_state got=rdy%b/busy%b want=rdy0/busy1", bus.in_ready, busy); end
      consume(0);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL single_release got=v%b/r%b/b%b want=v0/r1/b0", bus.out_valid, bus.in_ready, busy); end
      total++; if (beat_cnt !== '0) begin bad++; $display("FAIL single_cnt_clear got=%0d want=0", beat_cnt); end
      total++; if (bus.out_data !== W'(32'h1234)) begin bad++; $display("FAIL single_hold_idle got=%h want=1234", bus.out_data); end
   endtask

   task automatic test_carry_chain();
      int           lat;
      logic [W-1:0] exp;
      clear_beats();
      bd[0] = (W'(1) << (W - 1)) - W'(1);
      bd[1] = W'(1);
      bd[2] = W'(5);
      exp   = (W'(1) << (W - 1)) + W'(5);
      drive_sum(3, 0);
      wait_out(lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL carry_latency got=%0d want=%0d", lat, LAT); end
      total++; if (bus.out_data !== exp) begin bad++; $display("FAIL carry_data got=%h want=%h", bus.out_data, exp); end
      total++; if (beat_cnt !== CNT_W'(3)) begin bad++; $display("FAIL carry_beat_cnt got=%0d want=3", beat_cnt); end
      consume(1);
   endtask

   task automatic test_wrap();
      int lat;
      clear_beats();
      bd[0] = '1;
      bd[1] = W'(1);
      drive_sum(2, 1);
      wait_out(lat);
      total++; if (bus.out_data !== '0) begin bad++; $display("FAIL wrap_data got=%h want=0", bus.out_data); end
      consume(0);
   endtask

   task automatic test_back_to_back();
      int           lat;
      logic [W-1:0] exp_a;
      logic [W-1:0] b;
      bit           stable_ok;
      clear_beats();
      bd[0] = rand_w();
      bd[1] = rand_w();
      exp_a = model(2);
      b     = rand_w();
      drive_sum(2, 0);
      wait_out(lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = 1'b1;
`ifdef CSA_ACC_SUB_EN
      bus.in_neg   = 1'b0;
`endif
      stable_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp_a || bus.in_ready !== 1'b0) stable_ok = 1'b0;
      end
      total++; if (!stable_ok) begin bad++; $display("FAIL b2b_hold got=v%b/r%b/%h want=v1/r0/%h", bus.out_valid, bus.in_ready, bus.out_data, exp_a); end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_release got=v%b/r%b want=v0/r1", bus.out_valid, bus.in_ready); end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      total++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=r%b/b%b want=r0/b1", bus.in_ready, busy); end
      wait_out(lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_latency2 got=%0d want=%0d", lat, LAT); end
      total++; if (bus.out_data !== b) begin bad++; $display("FAIL b2b_data got=%h want=%h", bus.out_data, b); end
      consume(0);
   endtask

   task automatic test_reset_mid();
      int  lat;
      bit  quiet;
      clear_beats();
      bd[0] = rand_w();
      bd[1] = rand_w();
      drive_sum(2, 0);
      #2;
      rst = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=r%b/v%b/b%b want=r1/v0/b0", bus.in_ready, bus.out_valid, busy); end
      total++; if (beat_cnt !== '0 || bus.out_data !== '0) begin bad++; $display("FAIL midrst_data got=cnt%0d/%h want=cnt0/0", beat_cnt, bus.out_data); end
      @(negedge clk);
      rst = 1'b0;
      quiet = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) quiet = 1'b0;
      end
      total++; if (!quiet) begin bad++; $display("FAIL midrst_no_valid got=out_valid want=none"); end
      clear_beats();
      bd[0] = W'(7);
      drive_sum(1, 0);
      wait_out(lat);
      total++; if (bus.out_data !== W'(7)) begin bad++; $display("FAIL midrst_after got=%h want=7", bus.out_data); end
      consume(0);
   endtask

   task automatic test_random();
      int           lat;
      int           n;
      logic [W-1:0] exp;
      for (int t = 0; t < 25; t++) begin
         clear_beats();
         n = int'($urandom_range(6, 1));
         for (int i = 0; i < n; i++) begin
            bd[i] = rand_w();
`ifdef CSA_ACC_SUB_EN
            bn[i] = 1'($urandom_range(1, 0));
`endif
         end
         exp = model(n);
         drive_sum(n, 2);
         total++; if (tmo) begin bad++; $display("FAIL rand%0d_accept got=timeout want=accepted", t); end
         wait_out(lat);
         total++; if (lat !== LAT) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", t, lat, LAT); end
         total++; if (bus.out_data !== exp) begin bad++; $display("FAIL rand%0d_data got=%h want=%h", t, bus.out_data, exp); end
         total++; if (beat_cnt !== CNT_W'(n)) begin bad++; $display("FAIL rand%0d_beat_cnt got=%0d want=%0d", t, beat_cnt, n); end
         consume(int'($urandom_range(3, 0)));
      end
   endtask

   task automatic test_beat_sat();
      int           lat;
      logic [W-1:0] exp;
      clear_beats();
      for (int i = 0; i < 300; i++) bd[i] = rand_w();
      exp = model(300);
      drive_sum(300, 0);
      wait_out(lat);
      total++; if (beat_cnt !== '1) begin bad++; $display("FAIL sat_beat_cnt got=%0d want=255", beat_cnt); end
      total++; if (bus.out_data !== exp) begin bad++; $display("FAIL sat_data got=%h want=%h", bus.out_data, exp); end
      consume(0);
   endtask

`ifdef CSA_ACC_SUB_EN
   task automatic test_sub();
      int           lat;
      logic [W-1:0] exp;
      clear_beats();
      bd[0] = W'(100);
      bd[1] = W'(30);  bn[1] = 1'b1;
      bd[2] = W'(1);   bn[2] = 1'b1;
      drive_sum(3, 0);
      wait_out(lat);
      total++; if (bus.out_data !== W'(69)) begin bad++; $display("FAIL sub_data got=%h want=45", bus.out_data); end
      consume(0);
      clear_beats();
      bd[0] = W'(5);   bn[0] = 1'b1;
      exp   = '0 - W'(5);
      drive_sum(1, 0);
      wait_out(lat);
      total++; if (bus.out_data !== exp) begin bad++; $display("FAIL sub_neg_only got=%h want=%h", bus.out_data, exp); end
      consume(0);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total         = 0;
      bad           = 0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
`ifdef CSA_ACC_SUB_EN
      bus.in_neg    = 1'b0;
`endif
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_carry_chain();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_beat_sat();
`ifdef CSA_ACC_SUB_EN
      test_sub();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
